// File: rtl/ifft_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : ifft_frame_loader
// Description : Ping-pong frame assembler feeding a 16-point FFT/IFFT core.
// Revision    : 1.0 - initial release
// ============================================================================
module ifft_frame_loader #(
   parameter int N      = 16,
   parameter int DATA_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DATA_W-1:0]     s_real,
   input  logic [DATA_W-1:0]     s_imag,
   input  logic                  s_last,
   input  logic                  s_mode,
   output logic                  fft_start,
   output logic                  fft_mode,
   input  logic                  fft_done,
   output logic [N*DATA_W-1:0]   frame_real,
   output logic [N*DATA_W-1:0]   frame_imag,
   output logic                  err_last
);

   localparam int                c_IDX_W    = $clog2(N);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   logic [DATA_W-1:0]  r_mem_re [2][N];
   logic [DATA_W-1:0]  r_mem_im [2][N];
   logic [1:0]         r_mode;
   logic [1:0]         r_full;
   logic               r_wr_bank;
   logic [c_IDX_W-1:0] r_wr_idx;
   logic               r_rd_bank;
   logic               r_done_q;
   state_t             r_state;

   logic               w_accept;
   logic               w_fill;
   logic               w_release;

   assign s_ready   = ~r_full[r_wr_bank];
   assign w_accept  = s_valid & s_ready;
   assign w_fill    = w_accept & (r_wr_idx == c_LAST_IDX);
   // A done edge coinciding with the start pulse belongs to the previous job.
   assign w_release = (r_state == ST_BUSY) & ~fft_start & fft_done & ~r_done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
               r_mem_re[b][i] <= '0;
               r_mem_im[b][i] <= '0;
            end
         end
         r_mode    <= '0;
         r_wr_bank <= 1'b0;
         r_wr_idx  <= '0;
         err_last  <= 1'b0;
      end else begin
         err_last <= 1'b0;
         if (w_accept) begin
            r_mem_re[r_wr_bank][r_wr_idx] <= s_real;
            r_mem_im[r_wr_bank][r_wr_idx] <= s_imag;
            if (r_wr_idx == '0) begin
               r_mode[r_wr_bank] <= s_mode;
            end
            if (r_wr_idx == c_LAST_IDX) begin
               r_wr_bank <= ~r_wr_bank;
               r_wr_idx  <= '0;
               err_last  <= ~s_last;
            end else if (s_last) begin
               r_wr_idx  <= '0;
               err_last  <= 1'b1;
            end else begin
               r_wr_idx  <= r_wr_idx + 1'b1;
            end
         end
      end
   end

   // Fill and release always target different banks, so both may apply.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= '0;
      end else begin
         if (w_release) begin
            r_full[r_rd_bank] <= 1'b0;
         end
         if (w_fill) begin
            r_full[r_wr_bank] <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_rd_bank <= 1'b0;
         r_done_q  <= 1'b0;
         fft_start <= 1'b0;
      end else begin
         r_done_q  <= fft_done;
         fft_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (r_full[r_rd_bank]) begin
                  fft_start <= 1'b1;
                  r_state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (w_release) begin
                  r_rd_bank <= ~r_rd_bank;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign fft_mode = r_mode[r_rd_bank];

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_pack
         assign frame_real[gi*DATA_W +: DATA_W] = r_mem_re[r_rd_bank][gi];
         assign frame_imag[gi*DATA_W +: DATA_W] = r_mem_im[r_rd_bank][gi];
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ifft_frame_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifft_frame_loader
// Description : Self-checking bench for ifft_frame_loader with a frame-queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifft_frame_loader;

   localparam int N = 16;
   localparam int W = 12;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           s_valid = 1'b0;
   logic           s_last = 1'b0;
   logic           s_mode = 1'b0;
   logic [W-1:0]   s_real = '0;
   logic [W-1:0]   s_imag = '0;
   logic           s_ready;
   logic           fft_start;
   logic           fft_mode;
   logic           fft_done;
   logic           err_last;
   logic [N*W-1:0] frame_real;
   logic [N*W-1:0] frame_imag;

   logic           auto_core = 1'b0;
   logic           man_done = 1'b0;
   logic           core_done = 1'b0;

   int errors = 0;
   int checks = 0;

   assign fft_done = auto_core ? core_done : man_done;

   always #5 clk = ~clk;

   ifft_frame_loader #(.N(N), .DATA_W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_real     (s_real),
      .s_imag     (s_imag),
      .s_last     (s_last),
      .s_mode     (s_mode),
      .fft_start  (fft_start),
      .fft_mode   (fft_mode),
      .fft_done   (fft_done),
      .frame_real (frame_real),
      .frame_imag (frame_imag),
      .err_last   (err_last)
   );

   // ---------------- behavioural model: queue of completed frames ----------
   typedef struct packed {
      logic [N*W-1:0] re;
      logic [N*W-1:0] im;
      logic           mode;
   } frame_t;

   frame_t         q[$];
   frame_t         f;
   logic [N*W-1:0] p_re, p_im;
   logic           p_mode;
   int             p_cnt;
   bit             m_busy, m_start, m_err, m_done_q;
   bit             hs, rel, st;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         p_cnt = 0; p_re = '0; p_im = '0; p_mode = 1'b0;
         m_busy = 0; m_start = 0; m_err = 0; m_done_q = 0;
      end else begin
         hs  = s_valid && (q.size() < 2);
         rel = m_busy && !m_start && fft_done && !m_done_q;
         st  = !m_busy && (q.size() > 0);
         m_err = 0;
         if (rel) begin
            f = q.pop_front();
            m_busy = 0;
         end
         if (hs) begin
            p_re[p_cnt*W +: W] = s_real;
            p_im[p_cnt*W +: W] = s_imag;
            if (p_cnt == 0) p_mode = s_mode;
            if (p_cnt == N-1) begin
               f.re = p_re; f.im = p_im; f.mode = p_mode;
               q.push_back(f);
               m_err = !s_last;
               p_cnt = 0;
            end else if (s_last) begin
               m_err = 1;
               p_cnt = 0;
            end else begin
               p_cnt++;
            end
         end
         m_start = st;
         if (st) m_busy = 1;
         m_done_q = fft_done;
      end
   end

   task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("s_ready", {191'd0, s_ready}, {191'd0, q.size() < 2});
      chk("fft_start", {191'd0, fft_start}, {191'd0, m_start});
      chk("err_last", {191'd0, err_last}, {191'd0, m_err});
      if (rst_n && m_busy) begin
         chk("fft_mode", {191'd0, fft_mode}, {191'd0, q[0].mode});
         chk("frame_real", frame_real, q[0].re);
         chk("frame_imag", frame_imag, q[0].im);
      end
   end

   // ---------------- automatic core: random done after each start ---------
   int pend = 0, wait_cnt = 0, hold_cnt = 0;
   always @(negedge clk) begin
      if (!auto_core || !rst_n) begin
         pend = 0; wait_cnt = 0; hold_cnt = 0; core_done = 1'b0;
      end else begin
         if (fft_start) pend++;
         if (core_done) begin
            if (hold_cnt > 1) hold_cnt--;
            else core_done = 1'b0;
         end else if (pend > 0 && !fft_start) begin
            if (wait_cnt > 0) wait_cnt--;
            else begin
               core_done = 1'b1;
               hold_cnt  = $urandom_range(1, 3);
               wait_cnt  = $urandom_range(0, 8);
               pend--;
            end
         end
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [W-1:0] re, input logic [W-1:0] im,
                       input logic last, input logic mode, input int gap);
      int  n = 0;
      bit  ok = 0;
      s_valid = 1'b0;
      repeat (gap) tick();
      s_valid = 1'b1; s_real = re; s_imag = im; s_last = last; s_mode = mode;
      while (!ok) begin
         @(negedge clk);
         ok = s_ready;
         tick();
         n++;
         if (!ok && n > 400) begin
            checks++; errors++;
            $display("FAIL send_timeout: got no handshake expected one within 400 cycles");
            ok = 1;
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_frame(input int kind, input logic mode, input int gmax,
                             input int len, input bit with_last);
      for (int i = 0; i < len; i++) begin
         logic [W-1:0] re, im;
         case (kind)
            1: begin re = W'(i);       im = W'(-i); end
            2: begin re = W'(100 + i); im = W'(-i); end
            3: begin re = W'(200 + i); im = W'(i);  end
            default: begin re = W'($urandom); im = W'($urandom); end
         endcase
         send(re, im, with_last && (i == len-1), (i == 0) ? mode : 1'($urandom),
              $urandom_range(0, gmax));
      end
   endtask

   task automatic pulse_done();
      man_done = 1'b1; tick();
      man_done = 1'b0; tick();
   endtask

   logic [N*W-1:0] exp_re, exp_im;

   initial begin
      #100_000_000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      // Reset values
      repeat (3) tick();
      chk("rst_s_ready", {191'd0, s_ready}, 192'd1);
      chk("rst_fft_mode", {191'd0, fft_mode}, 192'd0);
      chk("rst_frame_real", frame_real, '0);
      chk("rst_frame_imag", frame_imag, '0);
      rst_n = 1'b1;
      tick();

      // Single frame: real=i, imag=-i, mode 1
      send_frame(1, 1'b1, 0, N, 1);
      chk("single_start_k", {191'd0, fft_start}, 192'd0);
      tick();
      chk("single_start_k1", {191'd0, fft_start}, 192'd1);
      for (int i = 0; i < N; i++) begin
         exp_re[i*W +: W] = W'(i);
         exp_im[i*W +: W] = W'(-i);
      end
      chk("single_real", frame_real, exp_re);
      chk("single_imag", frame_imag, exp_im);
      chk("single_mode", {191'd0, fft_mode}, 192'd1);
      tick();
      chk("single_start_k2", {191'd0, fft_start}, 192'd0);
      repeat (6) tick();
      pulse_done();

      // Ping-pong: A then B with done held low
      send_frame(2, 1'b0, 1, N, 1);
      send_frame(3, 1'b1, 1, N, 1);
      chk("pp_backpressure", {191'd0, s_ready}, 192'd0);
      chk("pp_shows_A", {180'd0, frame_real[W-1:0]}, 192'd100);
      repeat (3) tick();
      man_done = 1'b1; tick();
      man_done = 1'b0;
      chk("pp_ready_after_release", {191'd0, s_ready}, 192'd1);
      chk("pp_no_start_d", {191'd0, fft_start}, 192'd0);
      tick();
      chk("pp_start_d1", {191'd0, fft_start}, 192'd1);
      chk("pp_shows_B", {180'd0, frame_real[W-1:0]}, 192'd200);
      repeat (2) tick();
      pulse_done();

      // Early s_last on sample 5, then a clean frame
      send_frame(0, 1'b0, 0, 6, 1);
      chk("early_err", {191'd0, err_last}, 192'd1);
      repeat (4) tick();
      send_frame(0, 1'b1, 1, N, 1);
      repeat (3) tick();
      pulse_done();

      // Missing s_last
      send_frame(0, 1'b0, 0, N, 0);
      chk("nolast_err", {191'd0, err_last}, 192'd1);
      tick();
      chk("nolast_start", {191'd0, fft_start}, 192'd1);
      repeat (2) tick();
      pulse_done();

      // Done held high across the start pulse, released only on re-raise
      man_done = 1'b1;
      send_frame(0, 1'b1, 0, N, 1);
      repeat (5) tick();
      send_frame(0, 1'b0, 0, N, 1);
      chk("done_hold_full", {191'd0, s_ready}, 192'd0);
      man_done = 1'b0; tick();
      chk("done_low_full", {191'd0, s_ready}, 192'd0);
      man_done = 1'b1; tick();
      chk("done_reraise_release", {191'd0, s_ready}, 192'd1);
      tick();
      chk("done_next_start", {191'd0, fft_start}, 192'd1);
      man_done = 1'b0;
      repeat (2) tick();
      pulse_done();

      // Reset mid-load after 7 samples
      send_frame(0, 1'b1, 0, 7, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", {191'd0, s_ready}, 192'd1);
      chk("midrst_start", {191'd0, fft_start}, 192'd0);
      chk("midrst_real", frame_real, '0);
      chk("midrst_mode", {191'd0, fft_mode}, 192'd0);
      tick();
      rst_n = 1'b1;
      tick();
      send_frame(1, 1'b0, 0, N, 1);
      tick();
      chk("midrst_reload", frame_real, exp_re);
      repeat (2) tick();
      pulse_done();

      // Randomized traffic with an automatic core
      auto_core = 1'b1;
      for (int fr = 0; fr < 40; fr++) begin
         int sel;
         sel = $urandom_range(0, 9);
         if (sel == 0)      send_frame(0, 1'($urandom), 2, $urandom_range(1, N-1), 1);
         else if (sel == 1) send_frame(0, 1'($urandom), 2, N, 0);
         else               send_frame(0, 1'($urandom), 2, N, 1);
      end
      begin
         int n = 0;
         while ((q.size() != 0 || m_busy) && n < 500) begin
            tick();
            n++;
         end
         if (q.size() != 0 || m_busy) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d frames pending expected 0", q.size());
         end
      end
      auto_core = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
